reg_write_scoreboard: RTL
=========================

# reg_write_scoreboard

Parametrised successor to the processor's 5-to-32 register-select decoder. It decodes destination register addresses into one-hot write enables for the register file, registering them for one-cycle writeback alignment. It also keeps a per-register busy scoreboard set at issue and cleared at writeback, giving the pipeline read-after-write hazard flags and an issue handshake. It sits between decode/issue and the register file.

## Interface
- ADDR_WIDTH, 5: register address width.
- NUM_REGS, 2**ADDR_WIDTH: register count; must equal 2**ADDR_WIDTH.
- ZERO_REG_HARDWIRED, 1: when 1, register 0 is never written and never busy.
- BYPASS, 1: when 1, a writeback in the same cycle clears the hazard for issue and read checks.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- issue_en  in  1  issue request for an instruction that writes issue_rd.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- issue_ack  out  1  combinational; the issue is accepted this cycle.
- wb_en  in  1  writeback valid.
- wb_rd  in  ADDR_WIDTH  writeback destination.
- rs1, rs2  in  ADDR_WIDTH  source registers of the instruction in decode.
- rs1_busy, rs2_busy  out  1  combinational hazard flags.
- we_onehot  out  NUM_REGS  registered one-hot register-file write enable.
- busy  out  NUM_REGS  registered scoreboard vector.
- pending_count  out  ADDR_WIDTH+1  registered count of set busy bits.
- wb_err  out  1  sticky flag: writeback to a register that is not busy.

## Operation
- Decode: dec(a) is the one-hot of a, with bit 0 forced to 0 when ZERO_REG_HARDWIRED=1.
- clr = wb_en ? dec(wb_rd) & busy : 0. A writeback to a non-busy register is spurious: it sets wb_err and leaves busy unchanged. It still produces we_onehot, so the register file write happens.
- eff_busy = BYPASS ? busy & ~clr : busy.
- issue_ack = issue_en & ~eff_busy[issue_rd].
  - With ZERO_REG_HARDWIRED=1, an issue to register 0 is always acked and sets nothing.
- rsN_busy = eff_busy[rsN].
  - With ZERO_REG_HARDWIRED=1, rsN = 0 gives 0.
- set = issue_ack ? dec(issue_rd) : 0.
- Next state:
  - busy <= (busy & ~clr) | set.
  - A same-register, same-cycle writeback plus accepted issue leaves the bit set, because it now tracks the new write.
- pending_count <= popcount of next busy. Equivalently, the count adds +1 per new set bit and -1 per cleared bit not re-set. It never wraps, since it saturates naturally at NUM_REGS (or NUM_REGS-1 with ZERO_REG_HARDWIRED=1).
- we_onehot <= wb_en ? dec(wb_rd) : 0. At most one bit is set.
- An issue that is not acked is held by the requester. The block does not queue it, and the requester must keep issue_en/issue_rd stable until ack.

## Timing
- Reset is synchronous and wins over all other inputs in the same cycle.
  - After the reset edge: busy = 0, we_onehot = 0, pending_count = 0, wb_err = 0.
  - Combinational outputs follow the cleared state the next cycle.
- issue_ack, rs1_busy and rs2_busy are combinational from the current busy, wb and issue inputs, with no register in the path.
- An accepted issue is visible on busy and rsN_busy from the next cycle.
- A writeback asserted in cycle t:
  - we_onehot is valid in cycle t+1 (latency 1), for one cycle.
  - The busy bit clears at the t edge.
  - With BYPASS=1, the hazard is already clear in cycle t. With BYPASS=0, it clears in cycle t+1.
- wb_err rises the cycle after a spurious writeback and stays high until reset.
- Reset asserted mid-operation drops every pending entry. Writebacks that arrive after reset are spurious and set wb_err.

## Test plan
- Reset, then idle: busy = 0, we_onehot = 0, pending_count = 0, wb_err = 0, and issue_ack = 1 for issue_rd = 7.
- Issue rd=5, then next cycle set rs1 = 5 and issue rd=5 again: busy[5] = 1, rs1_busy = 1, issue_ack = 0, pending_count = 1.
- Writeback rd=5 in cycle t, with rs2 = 5 and issue rd=5 in the same cycle:
  - BYPASS=1: rs2_busy = 0, issue_ack = 1, busy[5] stays 1, we_onehot = 32'h20 at t+1.
  - BYPASS=0: issue_ack = 0.
- Register 0 with ZERO_REG_HARDWIRED=1: issue rd=0 is acked, busy stays 0, pending_count stays 0. Writeback rd=0 gives we_onehot = 0 and wb_err stays 0.
- Writeback rd=9 with busy[9] = 0: we_onehot = 32'h200 at t+1, and wb_err = 1 from t+1, still 1 ten cycles later.
- Issue registers 1 to 31 back-to-back: pending_count reaches 31. Reset mid-run returns busy and pending_count to 0 one edge later, with no wrap.

Source files
------------

// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - register write-enable decoder with busy scoreboard and RAW hazard flags
module reg_write_scoreboard #(
    parameter int ADDR_WIDTH         = 5,
    parameter int NUM_REGS           = 2 ** ADDR_WIDTH,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int BYPASS             = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ack,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [NUM_REGS-1:0]   we_onehot,
    output logic [NUM_REGS-1:0]   busy,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  wb_err
);

    // One-hot decode; register 0 is suppressed when it is hardwired so it
    // can never be written nor tracked as busy.
    function automatic logic [NUM_REGS-1:0] dec(input logic [ADDR_WIDTH-1:0] a);
        logic [NUM_REGS-1:0] d;
        d    = '0;
        d[a] = 1'b1;
        if (ZERO_REG_HARDWIRED != 0) begin
            d[0] = 1'b0;
        end
        return d;
    endfunction

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [NUM_REGS-1:0]  we_q, we_d;
    logic [ADDR_WIDTH:0]  cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [NUM_REGS-1:0]  wb_dec;
    logic [NUM_REGS-1:0]  iss_dec;
    logic [NUM_REGS-1:0]  clr;
    logic [NUM_REGS-1:0]  set;
    logic [NUM_REGS-1:0]  eff_busy;
    logic                 spurious;
    logic                 ack;

    // Scoreboard update: writebacks clear only bits that are actually busy,
    // accepted issues set theirs (a same-cycle clear+set keeps the bit, now
    // tracking the newer write).
    always_comb begin
        wb_dec   = dec(wb_rd);
        iss_dec  = dec(issue_rd);
        clr      = wb_en ? (wb_dec & busy_q) : '0;
        eff_busy = (BYPASS != 0) ? (busy_q & ~clr) : busy_q;
        ack      = issue_en & ~eff_busy[issue_rd];
        set      = ack ? iss_dec : '0;
        busy_d   = (busy_q & ~clr) | set;
        // A writeback whose decoded target is not busy is spurious; a write to
        // hardwired register 0 decodes to nothing and so never counts.
        spurious = wb_en & (|(wb_dec & ~busy_q));
        err_d    = err_q | spurious;
        we_d     = wb_en ? wb_dec : '0;
        cnt_d    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // State registers; synchronous reset drops every pending entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
            we_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Output mapping: hazard flags and ack are combinational from current state.
    always_comb begin
        issue_ack     = ack;
        rs1_busy      = eff_busy[rs1];
        rs2_busy      = eff_busy[rs2];
        we_onehot     = we_q;
        busy          = busy_q;
        pending_count = cnt_q;
        wb_err        = err_q;
    end

endmodule
